// File: rtl/gate_sweep_checker.sv
//==============================================================================
// Module  : gate_sweep_checker
// Brief   : Drives all four input pairs into a two-input gate block and checks
//           its AND/OR/NOT outputs against the truth table.
//           Optional macro GATE_SWEEP_LOOP_EN: a start held in DONE re-sweeps
//           with accumulating results.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_sweep_checker #(
  parameter int HOLD_CYCLES = 2   // legal range 1..255
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oA,
  output logic       oB,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oErrCnt,
  output logic [3:0] oFailVec
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_next;
  logic [1:0] vec, vec_next;
  logic [7:0] hold_cnt, hold_next;
  logic [3:0] err_cnt, err_next;
  logic [3:0] fail_vec, fail_next;
  logic       a_q, b_q, a_next, b_next;
  logic       sample;
  logic       mismatch;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      vec      <= 2'd0;
      hold_cnt <= 8'd0;
      err_cnt  <= 4'd0;
      fail_vec <= 4'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      state    <= state_next;
      vec      <= vec_next;
      hold_cnt <= hold_next;
      err_cnt  <= err_next;
      fail_vec <= fail_next;
      a_q      <= a_next;
      b_q      <= b_next;
    end
  end

  assign sample   = (state == DRIVE) && (hold_cnt == HOLD_LAST);
  // One failing vector counts once, however many of the three outputs are wrong.
  assign mismatch = (iAnd != (a_q & b_q)) || (iOr != (a_q | b_q)) || (iNot != ~a_q);

  always_comb begin
    state_next = state;
    vec_next   = vec;
    hold_next  = hold_cnt;
    err_next   = err_cnt;
    fail_next  = fail_vec;
    a_next     = a_q;
    b_next     = b_q;

    unique case (state)
      IDLE: begin
        if (iStart) begin
          state_next = DRIVE;
          vec_next   = 2'd0;
          hold_next  = 8'd0;
          a_next     = 1'b0;
          b_next     = 1'b0;
          err_next   = 4'd0;
          fail_next  = 4'd0;
        end
      end

      DRIVE: begin
        hold_next = hold_cnt + 8'd1;
        if (sample) begin
          if (mismatch) begin
            fail_next[vec] = 1'b1;
            if (err_cnt != 4'hF) err_next = err_cnt + 4'd1;
          end
          hold_next = 8'd0;
          if (vec != 2'd3) begin
            vec_next          = vec + 2'd1;
            {a_next, b_next}  = vec + 2'd1;
          end else begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (iStart) begin
          state_next = DRIVE;
          vec_next   = 2'd0;
          hold_next  = 8'd0;
          a_next     = 1'b0;
          b_next     = 1'b0;
`ifdef GATE_SWEEP_LOOP_EN
          // Results carry over so repeated passes accumulate.
          err_next   = err_cnt;
          fail_next  = fail_vec;
`else
          err_next   = 4'd0;
          fail_next  = 4'd0;
`endif
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign oA       = a_q;
  assign oB       = b_q;
  assign oBusy    = (state == DRIVE);
  assign oDone    = (state == DONE);
  assign oPass    = (state == DONE) && (err_cnt == 4'd0);
  assign oErrCnt  = err_cnt;
  assign oFailVec = fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
//==============================================================================
// Module  : tb_gate_sweep_checker
// Brief   : Scoreboard bench for gate_sweep_checker (HOLD_CYCLES=2 and =1).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gate_sweep_checker;

  typedef struct {
    int         dut;
    logic [3:0] fv;
    logic [3:0] err;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_s;
  logic [1:0] and_s, or_s, not_s;
  logic [1:0] a_s, b_s, busy_s, done_s, pass_s;
  logic [3:0] err_s [2];
  logic [3:0] fv_s  [2];
  // 0 correct, 1 AND stuck-at-1, 2 NOT equals A, 3 OR stuck-at-0
  int         mode  [2];

  always #5 clk = ~clk;

  gate_sweep_checker #(.HOLD_CYCLES(2)) u_dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_s[0]),
    .iAnd(and_s[0]), .iOr(or_s[0]), .iNot(not_s[0]),
    .oA(a_s[0]), .oB(b_s[0]), .oBusy(busy_s[0]), .oDone(done_s[0]),
    .oPass(pass_s[0]), .oErrCnt(err_s[0]), .oFailVec(fv_s[0])
  );

  gate_sweep_checker #(.HOLD_CYCLES(1)) u_dut1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_s[1]),
    .iAnd(and_s[1]), .iOr(or_s[1]), .iNot(not_s[1]),
    .oA(a_s[1]), .oB(b_s[1]), .oBusy(busy_s[1]), .oDone(done_s[1]),
    .oPass(pass_s[1]), .oErrCnt(err_s[1]), .oFailVec(fv_s[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int H = (d == 0) ? 2 : 1;
    int   busy_cyc  = 0;
    logic prev_done = 1'b0;
    exp_t e;

    assign and_s[d] = (mode[d] == 1) ? 1'b1 : (a_s[d] & b_s[d]);
    assign or_s[d]  = (mode[d] == 3) ? 1'b0 : (a_s[d] | b_s[d]);
    assign not_s[d] = (mode[d] == 2) ? a_s[d] : ~a_s[d];

    always @(negedge clk) begin
      if (busy_s[d]) begin
        check($sformatf("vector_d%0d", d), int'({a_s[d], b_s[d]}), busy_cyc / H);
        busy_cyc++;
      end
      if (done_s[d] && !prev_done) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_done_d%0d", d), 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("sb_dut_d%0d", d), e.dut, d);
          check($sformatf("failvec_d%0d", d), int'(fv_s[d]), int'(e.fv));
          check($sformatf("errcnt_d%0d", d), int'(err_s[d]), int'(e.err));
          check($sformatf("pass_d%0d", d), int'(pass_s[d]), int'(e.pass));
          check($sformatf("latency_d%0d", d), busy_cyc, e.lat);
        end
        busy_cyc = 0;
      end
      if (!busy_s[d] && !done_s[d]) busy_cyc = 0;
      prev_done = done_s[d];
    end
  end

  task automatic push(input int d, input logic [3:0] fv, input logic [3:0] err,
                      input logic pass, input int lat);
    exp_t e;
    e.dut = d; e.fv = fv; e.err = err; e.pass = pass; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk) start_s[d] = 1'b1;
    @(negedge clk) start_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int n = 0;
    while (done_s[d] && n < budget) begin @(negedge clk); n++; end
    while (!done_s[d] && n < budget) begin @(negedge clk); n++; end
    if (!done_s[d]) check($sformatf("timeout_d%0d", d), 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_A"}, int'(a_s[0]), 0);
    check({tag, "_B"}, int'(b_s[0]), 0);
    check({tag, "_busy"}, int'(busy_s[0]), 0);
    check({tag, "_done"}, int'(done_s[0]), 0);
    check({tag, "_pass"}, int'(pass_s[0]), 0);
    check({tag, "_err"}, int'(err_s[0]), 0);
    check({tag, "_fv"}, int'(fv_s[0]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_s = 2'b00; mode[0] = 0; mode[1] = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    push(0, 4'b0000, 4'd0, 1'b1, 8);
    pulse_start(0); wait_done(0, 40);

    mode[0] = 1;
    push(0, 4'b0111, 4'd3, 1'b0, 8);
    pulse_start(0); wait_done(0, 40);

    mode[0] = 2;
    push(0, 4'b1111, 4'd4, 1'b0, 8);
    pulse_start(0); wait_done(0, 40);

    mode[0] = 0;
    push(0, 4'b0000, 4'd0, 1'b1, 8);
    pulse_start(0); wait_done(0, 40);

    // Abort during the vec=2 hold window, before its sample edge.
    pulse_start(0);
    repeat (5) @(negedge clk);
    check("pre_rst_ab", int'({a_s[0], b_s[0]}), 2);
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 4'b0000, 4'd0, 1'b1, 8);
    pulse_start(0); wait_done(0, 40);

`ifdef GATE_SWEEP_LOOP_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mode[0] = 3;
    push(0, 4'b1110, 4'd3, 1'b0, 8);
    push(0, 4'b1110, 4'd6, 1'b0, 8);
    push(0, 4'b1110, 4'd9, 1'b0, 8);
    @(negedge clk) start_s[0] = 1'b1;
    repeat (3) wait_done(0, 40);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("loop_hold_done", int'(done_s[0]), 1);
    check("loop_hold_err", int'(err_s[0]), 9);
    check("loop_hold_fv", int'(fv_s[0]), 4'b1110);
`else
    mode[0] = 1;
    push(0, 4'b0111, 4'd3, 1'b0, 8);
    push(0, 4'b0111, 4'd3, 1'b0, 8);
    @(negedge clk) start_s[0] = 1'b1;
    repeat (2) wait_done(0, 40);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("held_done", int'(done_s[0]), 1);
    check("held_err", int'(err_s[0]), 3);
`endif

    // HOLD_CYCLES=1 instance: a start pulse mid-sweep must be ignored.
    push(1, 4'b0000, 4'd0, 1'b1, 4);
    pulse_start(1);
    @(negedge clk) start_s[1] = 1'b1;
    @(negedge clk) start_s[1] = 1'b0;
    wait_done(1, 20);

    mode[1] = 2;
    push(1, 4'b1111, 4'd4, 1'b0, 4);
    pulse_start(1); wait_done(1, 20);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
